// File: rtl/interval_timer_pkg.sv
// interval_timer_pkg
//   Shared constants for the memory-mapped interval timer: register word
//   offsets (addr[3:2]), CTRL bit positions, mode encodings and FSM state
//   encodings. Also provides a small helper used to decode the MODE field.
package interval_timer_pkg;

   // Register word offsets, decoded from addr[3:2]
   localparam logic [1:0] TIMER_CTRL   = 2'd0;
   localparam logic [1:0] TIMER_PRESET = 2'd1;
   localparam logic [1:0] TIMER_COUNT  = 2'd2;

   // CTRL bit positions
   localparam int EN_POS   = 0;
   localparam int MODE_LSB = 1;
   localparam int MODE_MSB = 2;
   localparam int TIM_POS  = 3;

   // MODE encodings; 2 and 3 are treated as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

   // FSM state encodings
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CNT  = 2'd2;
   localparam logic [1:0] S_INT  = 2'd3;

   // Only the exact reload encoding reloads; everything else is one-shot.
   function automatic logic mode_is_reload(input logic [1:0] mode);
      return mode == MODE_RELOAD;
   endfunction

endpackage

// File: rtl/interval_timer_if.sv
// interval_timer_if
//   Peripheral bus between the data-memory bridge (master) and the timer
//   (slave).
//   addr         : byte address, only addr[3:2] is decoded by the timer
//   write_enable : one-cycle write strobe
//   write_data   : write data
//   read_data    : combinational read data of the register selected by addr
interface interval_timer_if;
   logic [31:0] addr;
   logic        write_enable;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (
      output addr,
      output write_enable,
      output write_data,
      input  read_data
   );

   modport slave (
      input  addr,
      input  write_enable,
      input  write_data,
      output read_data
   );
endinterface

// File: rtl/interval_timer.sv
// interval_timer
//   Memory-mapped countdown timer with three word registers (CTRL, PRESET,
//   COUNT). One-shot mode raises a level interrupt that holds until CTRL is
//   written; auto-reload mode produces a one-cycle pulse each period.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : peripheral bus slave port (addr/write_enable/write_data/read_data)
//   IRQ   : interrupt request, CTRL.IM & irq_flag
module interval_timer
   import interval_timer_pkg::*;
#(
   parameter int COUNT_WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   interval_timer_if.slave   bus,
   output logic              IRQ
);

   logic [3:0]             ctrl_q,     ctrl_d;
   logic [COUNT_WIDTH-1:0] preset_q,   preset_d;
   logic [COUNT_WIDTH-1:0] count_q,    count_d;
   logic                   irq_flag_q, irq_flag_d;
   logic [1:0]             state_q,    state_d;

   logic [1:0]  reg_sel;
   logic        ctrl_en;
   logic [31:0] read_mux;
   logic        unused_addr_bits;

   assign reg_sel = bus.addr[3:2];
   assign ctrl_en = ctrl_q[EN_POS];

   // Remaining address bits are intentionally ignored (no aliasing checks).
   assign unused_addr_bits = ^{bus.addr[31:4], bus.addr[1:0]};

   always_comb begin
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;
      state_d    = state_q;

      // FSM decisions look only at the pre-edge register values.
      case (state_q)
         S_IDLE: begin
            if (ctrl_en) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            count_d = preset_q;
            state_d = S_CNT;
         end
         S_CNT: begin
            if (!ctrl_en) begin
               state_d = S_IDLE;
            end else if (count_q > COUNT_WIDTH'(1)) begin
               count_d = count_q - COUNT_WIDTH'(1);
            end else begin
               // Expiry at 1 (or a PRESET of 0) ends at 0; never wraps.
               count_d    = '0;
               irq_flag_d = 1'b1;
               state_d    = S_INT;
            end
         end
         default: begin // S_INT
            if (mode_is_reload(ctrl_q[MODE_MSB:MODE_LSB])) begin
               // Pulse only; IDLE reloads because EN is still set.
               irq_flag_d = 1'b0;
            end else begin
               // Level interrupt; flag held until software writes CTRL.
               ctrl_d[EN_POS] = 1'b0;
            end
            state_d = S_IDLE;
         end
      endcase

      // Bus writes are applied last so they override FSM updates of CTRL
      // and irq_flag on the same edge.
      if (bus.write_enable) begin
         case (reg_sel)
            TIMER_CTRL: begin
               ctrl_d     = bus.write_data[3:0];
               irq_flag_d = 1'b0;
            end
            TIMER_PRESET: begin
               preset_d = bus.write_data[COUNT_WIDTH-1:0];
            end
            default: ; // COUNT and offset 3 are read-only
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
         state_q    <= S_IDLE;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
         state_q    <= state_d;
      end
   end

   always_comb begin
      read_mux = '0;
      case (reg_sel)
         TIMER_CTRL:   read_mux = {28'd0, ctrl_q};
         TIMER_PRESET: read_mux = 32'(preset_q);
         TIMER_COUNT:  read_mux = 32'(count_q);
         default:      read_mux = '0;
      endcase
   end

   assign bus.read_data = read_mux;
   assign IRQ           = ctrl_q[TIM_POS] & irq_flag_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer
//   Self-checking bench for interval_timer. Directed scenarios plus random
//   trials compared against a timeline model computed arithmetically from
//   the enable edge W (expiry at W+max(P,1)+2, reload period max(P,1)+3).
module tb_interval_timer;

   logic clk;
   logic reset;
   logic IRQ;
   int   tests_run;
   int   tests_failed;

   interval_timer_if bus ();

   interval_timer #(.COUNT_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .IRQ   (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
      bus.addr         = {28'd0, off, 2'b00};
      bus.write_data   = data;
      bus.write_enable = 1'b1;
      step();
      bus.write_enable = 1'b0;
      bus.addr         = '0;
   endtask

   task automatic rd(input logic [1:0] off, output logic [31:0] data);
      bus.addr = {28'd0, off, 2'b00};
      #1;
      data = bus.read_data;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      bus_write(2'd1, 32'h0000_1234);
      bus_write(2'd0, 32'h0000_0008);
      do_reset();
      for (int off = 0; off < 4; off++) begin
         rd(off[1:0], v);
         tests_run++;
         if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_read off=%0d: got %h expected 0", off * 4, v);
         end
      end
      tests_run++;
      if (IRQ !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_irq: got %b expected 0", IRQ);
      end
      $display("[TB] reset: checked offsets 0,4,8,12 and IRQ");
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      logic [31:0] exp_cnt;
      do_reset();
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'h9);                 // edge W
      for (int n = 1; n <= 10; n++) begin
         step();
         rd(2'd2, v);
         exp_cnt = (n < 2) ? 32'd0 : (n <= 4) ? 32'(5 - n) : 32'd0;
         tests_run++;
         if (v !== exp_cnt) begin
            tests_failed++;
            $display("FAIL oneshot_count n=%0d: got %0d expected %0d", n, v, exp_cnt);
         end
         tests_run++;
         if (IRQ !== (n >= 5)) begin
            tests_failed++;
            $display("FAIL oneshot_irq n=%0d: got %b expected %b", n, IRQ, (n >= 5));
         end
         rd(2'd0, v);
         tests_run++;
         if (v !== ((n >= 6) ? 32'h8 : 32'h9)) begin
            tests_failed++;
            $display("FAIL oneshot_ctrl n=%0d: got %h expected %h", n, v, (n >= 6) ? 32'h8 : 32'h9);
         end
      end
      bus_write(2'd0, 32'h0);
      tests_run++;
      if (IRQ !== 1'b0) begin
         tests_failed++;
         $display("FAIL oneshot_clear: got %b expected 0", IRQ);
      end
      $display("[TB] oneshot: preset=3 ctrl=0x9 then ctrl=0x0");
   endtask

   task automatic test_reload();
      logic [31:0] v;
      int m;
      logic [31:0] exp_cnt;
      logic exp_irq;
      do_reset();
      bus_write(2'd1, 32'd2);
      bus_write(2'd0, 32'hB);
      for (int n = 1; n <= 20; n++) begin
         step();
         m       = (n >= 2) ? (n - 2) % 5 : 0;
         exp_cnt = (n < 2) ? 32'd0 : (m < 2) ? 32'(2 - m) : 32'd0;
         exp_irq = (n >= 4) && ((n - 4) % 5 == 0);
         rd(2'd2, v);
         tests_run++;
         if (v !== exp_cnt) begin
            tests_failed++;
            $display("FAIL reload_count n=%0d: got %0d expected %0d", n, v, exp_cnt);
         end
         tests_run++;
         if (IRQ !== exp_irq) begin
            tests_failed++;
            $display("FAIL reload_irq n=%0d: got %b expected %b", n, IRQ, exp_irq);
         end
      end
      $display("[TB] reload: preset=2 ctrl=0xB over 20 cycles");
   endtask

   task automatic test_masked();
      logic [31:0] v;
      do_reset();
      bus_write(2'd1, 32'd1);
      bus_write(2'd0, 32'h1);
      for (int n = 1; n <= 8; n++) begin
         step();
         tests_run++;
         if (IRQ !== 1'b0) begin
            tests_failed++;
            $display("FAIL masked_irq n=%0d: got %b expected 0", n, IRQ);
         end
         rd(2'd0, v);
         tests_run++;
         if (v !== ((n >= 4) ? 32'h0 : 32'h1)) begin
            tests_failed++;
            $display("FAIL masked_ctrl n=%0d: got %h expected %h", n, v, (n >= 4) ? 32'h0 : 32'h1);
         end
      end
      $display("[TB] masked: preset=1 ctrl=0x1");
   endtask

   task automatic test_pause();
      logic [31:0] v;
      do_reset();
      bus_write(2'd1, 32'd10);
      bus_write(2'd0, 32'h9);
      for (int n = 1; n <= 5; n++) step();
      rd(2'd2, v);
      tests_run++;
      if (v !== 32'd7) begin
         tests_failed++;
         $display("FAIL pause_pre: got %0d expected 7", v);
      end
      bus_write(2'd0, 32'h8);                 // lands on the edge giving COUNT=6
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) step();
         rd(2'd2, v);
         tests_run++;
         if (v !== 32'd6) begin
            tests_failed++;
            $display("FAIL pause_hold k=%0d: got %0d expected 6", k, v);
         end
      end
      bus_write(2'd0, 32'h9);                 // edge R
      step();
      step();
      rd(2'd2, v);
      tests_run++;
      if (v !== 32'd10) begin
         tests_failed++;
         $display("FAIL pause_reload: got %0d expected 10", v);
      end
      bus_write(2'd2, 32'h55);
      rd(2'd2, v);
      tests_run++;
      if (v !== 32'd9) begin
         tests_failed++;
         $display("FAIL count_readonly: got %0d expected 9", v);
      end
      // PRESET=0 expires at W+3 like PRESET=1
      do_reset();
      bus_write(2'd1, 32'd0);
      bus_write(2'd0, 32'h9);
      for (int n = 1; n <= 4; n++) begin
         step();
         tests_run++;
         if (IRQ !== (n >= 3)) begin
            tests_failed++;
            $display("FAIL preset0_irq n=%0d: got %b expected %b", n, IRQ, (n >= 3));
         end
      end
      $display("[TB] pause: hold at 6, reload 10, COUNT write ignored, preset 0");
   endtask

   task automatic test_collision();
      logic [31:0] v;
      do_reset();
      bus_write(2'd1, 32'd2);
      bus_write(2'd0, 32'h9);
      for (int n = 1; n <= 4; n++) step();
      tests_run++;
      if (IRQ !== 1'b1) begin
         tests_failed++;
         $display("FAIL collide_pre_irq: got %b expected 1", IRQ);
      end
      bus_write(2'd0, 32'h9);                 // same edge as INT processing
      rd(2'd0, v);
      tests_run++;
      if (v !== 32'h9) begin
         tests_failed++;
         $display("FAIL collide_ctrl: got %h expected 9", v);
      end
      tests_run++;
      if (IRQ !== 1'b0) begin
         tests_failed++;
         $display("FAIL collide_irq_clr: got %b expected 0", IRQ);
      end
      step();
      step();
      rd(2'd2, v);
      tests_run++;
      if (v !== 32'd2) begin
         tests_failed++;
         $display("FAIL collide_restart: got %0d expected 2", v);
      end
      step();
      step();
      tests_run++;
      if (IRQ !== 1'b1) begin
         tests_failed++;
         $display("FAIL collide_reexpire: got %b expected 1", IRQ);
      end
      // reset while counting
      do_reset();
      bus_write(2'd1, 32'd10);
      bus_write(2'd0, 32'h9);
      for (int n = 1; n <= 8; n++) step();
      rd(2'd2, v);
      tests_run++;
      if (v !== 32'd4) begin
         tests_failed++;
         $display("FAIL midreset_pre: got %0d expected 4", v);
      end
      do_reset();
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         rd(2'd2, v);
         tests_run++;
         if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL midreset_count k=%0d: got %0d expected 0", k, v);
         end
         tests_run++;
         if (IRQ !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_irq k=%0d: got %b expected 0", k, IRQ);
         end
      end
      rd(2'd0, v);
      tests_run++;
      if (v !== 32'd0) begin
         tests_failed++;
         $display("FAIL midreset_ctrl: got %h expected 0", v);
      end
      $display("[TB] collision: ctrl write on INT edge; reset at COUNT=4");
   endtask

   task automatic test_random();
      logic [31:0] v;
      logic [3:0]  ctrl;
      logic [31:0] exp_cnt;
      logic [31:0] exp_ctrl;
      logic        exp_irq;
      int p, pe, period, m, mode, im;
      bit reload;
      for (int t = 0; t < 10; t++) begin
         p      = $urandom_range(0, 6);
         mode   = $urandom_range(0, 3);
         im     = $urandom_range(0, 1);
         ctrl   = {im[0], mode[1:0], 1'b1};
         reload = (mode == 1);
         pe     = (p == 0) ? 1 : p;
         period = pe + 3;
         $display("[TB] random trial %0d: preset=%0d mode=%0d im=%0d", t, p, mode, im);
         do_reset();
         bus_write(2'd1, 32'(p));
         bus_write(2'd0, {28'd0, ctrl});
         for (int n = 1; n <= 2 * period + 3; n++) begin
            step();
            m        = (n < 2) ? 0 : reload ? (n - 2) % period : n - 2;
            exp_cnt  = (n < 2) ? 32'd0 : (m < pe) ? 32'(p - m) : 32'd0;
            exp_irq  = reload ? (im == 1 && n >= 2 && m == pe) : (im == 1 && n >= pe + 2);
            exp_ctrl = (!reload && n >= pe + 3) ? {28'd0, ctrl & 4'hE} : {28'd0, ctrl};
            rd(2'd2, v);
            tests_run++;
            if (v !== exp_cnt) begin
               tests_failed++;
               $display("FAIL rand_count t=%0d n=%0d: got %0d expected %0d", t, n, v, exp_cnt);
            end
            rd(2'd0, v);
            tests_run++;
            if (v !== exp_ctrl) begin
               tests_failed++;
               $display("FAIL rand_ctrl t=%0d n=%0d: got %h expected %h", t, n, v, exp_ctrl);
            end
            tests_run++;
            if (IRQ !== exp_irq) begin
               tests_failed++;
               $display("FAIL rand_irq t=%0d n=%0d: got %b expected %b", t, n, IRQ, exp_irq);
            end
         end
      end
   endtask

   initial begin
      tests_run        = 0;
      tests_failed     = 0;
      reset            = 1'b1;
      bus.addr         = '0;
      bus.write_enable = 1'b0;
      bus.write_data   = '0;
      step();
      reset = 1'b0;
      test_reset();
      test_oneshot();
      test_reload();
      test_masked();
      test_pause();
      test_collision();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Memory-mapped countdown timer on the peripheral bus behind the data-memory bridge.
- Its IRQ output drives one bit of the CP0 HWInt[5:0] input, so it is the upstream source of hardware interrupts.
- The CPU programs it with sw/lw to three word registers: CTRL, PRESET and COUNT.
- Two modes: one-shot with a level interrupt, and auto-reload with a 1-cycle interrupt pulse.

Parameters:
- COUNT_WIDTH, 32, width of the PRESET and COUNT registers (bus data is always 32 bits; zero-extend on read).

Ports:
- clk  input  1  system clock; one clock domain only.
- reset  input  1  synchronous reset, active-high.
- addr  input  32  byte address; only addr[3:2] is decoded. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- write_enable  input  1  bus write strobe, valid for one cycle.
- write_data  input  32  bus write data.
- read_data  output  32  combinational read of the register selected by addr.
- IRQ  output  1  interrupt request, wired to a CP0 HWInt bit.

Behaviour:
- Reset: on the rising edge with reset=1, CTRL=0, PRESET=0, COUNT=0, irq_flag=0 and state=IDLE. IRQ=0 from then on. Reset mid-count aborts the count immediately.
- CTRL bit fields:
  - [0] EN: count enable.
  - [2:1] MODE: 0 = one-shot; 1 = auto-reload; 2 and 3 behave as 0.
  - [3] IM: interrupt mask, 1 = allow IRQ.
  - [31:4] not stored; read as 0.
- Reads: CTRL, PRESET and COUNT read as stored (zero-extended). Offset 3 reads 0. No read side effects.
- Writes:
  - CTRL write stores write_data[3:0] and clears irq_flag.
  - PRESET write stores the value; it takes effect only at the next LOAD.
  - COUNT and offset 3 are read-only; writes are ignored.
- Priority: FSM decisions use pre-edge register values. A CPU write to CTRL on the same edge as an FSM update of CTRL (clearing EN) wins.
- IRQ = CTRL[3] & irq_flag, combinational from registers.
- FSM states (encodings 0..3):
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE with COUNT held. Else if COUNT > 1, COUNT <= COUNT-1. Else COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, mode 0: CTRL[0] <= 0; go to IDLE; irq_flag stays set until a CTRL write.
  - INT, mode 1: irq_flag <= 0; go to IDLE, which reloads because EN is still 1.
- Latency: for a CTRL write enabling the timer at edge W, irq_flag rises at edge W+max(P,1)+2, where P = PRESET. PRESET of 0 and 1 both expire at W+3.
- Mode-1 period is max(P,1)+3 cycles, with IRQ high for exactly 1 cycle.
- Clearing EN mid-count freezes COUNT. Re-enabling goes through LOAD, so counting restarts from PRESET rather than resuming.
- IM=0 masks IRQ but irq_flag still sets. Setting IM later raises IRQ only if irq_flag was not cleared; a CTRL write clears it, so that path applies only in mode 0 when IM is set by another path. The bench treats IM as static per test.
- Counter arithmetic is unsigned modulo 2^COUNT_WIDTH; no wrap can occur because decrement stops at 1.

Decomposition:
- Add to the shared macros.v:
  - Offsets TIMER_CTRL, TIMER_PRESET, TIMER_COUNT.
  - CTRL bit positions EN_POS, MODE_MSB/LSB, TIM_POS.
  - Mode encodings MODE_ONESHOT, MODE_RELOAD.
  - State encodings S_IDLE, S_LOAD, S_CNT, S_INT.
- Single module; no sub-module is warranted.
- The bridge instantiates it. The top level connects IRQ to HWInt[0].

Test Plan:
- Reset then read all offsets: read_data = 0 for offsets 0, 4, 8 and 12; IRQ = 0.
- One-shot: PRESET=3, then CTRL=0x9 at edge W. COUNT reads 3,2,1 after edges W+2..W+4 and 0 after W+5. IRQ is 1 from W+5. CTRL reads 0x8 after W+6. IRQ stays 1 until CTRL=0x0 is written, then drops next cycle.
- Auto-reload: PRESET=2, CTRL=0xB. IRQ pulses 1 cycle, first after edge W+4, then every 5 cycles; COUNT cycles 2,1,0 indefinitely.
- Masked: PRESET=1, CTRL=0x1. State reaches INT at W+3 and CTRL reads 0x0 afterwards, but IRQ stays 0 throughout.
- Pause and edge cases: PRESET=10, enable, then write CTRL=0x8 when COUNT=6. COUNT holds 6 for 5 cycles. Re-enabling reloads 10. A write to COUNT (0x55) is ignored. PRESET=0 expires like 1.
- Collisions and reset: a CTRL=0x9 write on the same edge as mode-0 INT leaves EN=1 and restarts the count. A reset asserted while COUNT=4 gives COUNT=0, IRQ=0 and IDLE next cycle.
